// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready/done handshake.
// Produces the product plus a sign/magnitude split for the BCD converter.
module booth_mult_seq #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     num_1,
  input  logic [WIDTH-1:0]     num_2,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   mult_result,
  output logic [2*WIDTH-1:0]   magnitude,
  output logic                 sign
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] N_ITER = CW'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state;
  state_t state_next;

  // The extra top bit keeps A-M in range when M is the most negative operand.
  logic [WIDTH:0]       acc;
  logic [WIDTH:0]       mcand;
  logic [WIDTH:0]       mplier;
  logic                 q_prev;
  logic [CW-1:0]        count;

  logic [WIDTH:0]       num_1_ext;
  logic [WIDTH:0]       num_2_ext;
  logic [WIDTH:0]       acc_sum;
  logic [WIDTH:0]       acc_next;
  logic [WIDTH:0]       mplier_next;
  logic                 q_prev_next;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   product_mag;
  logic                 product_sign;
  logic                 last_iter;

  assign last_iter = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    busy  = (state == CALC);
    done  = (state == DONE);
  end

  // Unsigned operands are zero-extended so the signed Booth core sees them as positive.
  always_comb begin
    num_1_ext = {SIGNED & num_1[WIDTH-1], num_1};
    num_2_ext = {SIGNED & num_2[WIDTH-1], num_2};
  end

  always_comb begin
    case ({mplier[0], q_prev})
      2'b01:   acc_sum = acc + mcand;
      2'b10:   acc_sum = acc - mcand;
      default: acc_sum = acc;
    endcase
    acc_next     = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
    mplier_next  = {acc_sum[0], mplier[WIDTH:1]};
    q_prev_next  = mplier[0];
    product      = {acc_next[WIDTH-2:0], mplier_next};
    product_sign = SIGNED & product[2*WIDTH-1];
    product_mag  = product_sign ? -product : product;
  end

  // Results are captured only on the final iteration and otherwise held.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      q_prev      <= 1'b0;
      count       <= '0;
      mult_result <= '0;
      magnitude   <= '0;
      sign        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            mcand  <= num_1_ext;
            mplier <= num_2_ext;
            acc    <= '0;
            q_prev <= 1'b0;
            count  <= N_ITER;
          end
        end
        CALC: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          q_prev <= q_prev_next;
          count  <= count - CW'(1);
          if (last_iter) begin
            mult_result <= product;
            magnitude   <= product_mag;
            sign        <= product_sign;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: signed 8-bit, unsigned 8-bit and signed 16-bit
// instances checked every cycle against a timing/arithmetic model, plus literal checks.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        v_s8 = 1'b0, v_u8 = 1'b0, v_s16 = 1'b0;
  logic [7:0]  a_s8 = '0, b_s8 = '0, a_u8 = '0, b_u8 = '0;
  logic [15:0] a_s16 = '0, b_s16 = '0;

  logic        r_s8, by_s8, d_s8, sg_s8;
  logic        r_u8, by_u8, d_u8, sg_u8;
  logic        r_s16, by_s16, d_s16, sg_s16;
  logic [15:0] res_s8, mag_s8, res_u8, mag_u8;
  logic [31:0] res_s16, mag_s16;

  booth_mult_seq #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .reset(reset), .valid(v_s8), .num_1(a_s8), .num_2(b_s8),
    .ready(r_s8), .busy(by_s8), .done(d_s8),
    .mult_result(res_s8), .magnitude(mag_s8), .sign(sg_s8));

  booth_mult_seq #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .reset(reset), .valid(v_u8), .num_1(a_u8), .num_2(b_u8),
    .ready(r_u8), .busy(by_u8), .done(d_u8),
    .mult_result(res_u8), .magnitude(mag_u8), .sign(sg_u8));

  booth_mult_seq #(.WIDTH(16), .SIGNED(1'b1)) u_s16 (
    .clk(clk), .reset(reset), .valid(v_s16), .num_1(a_s16), .num_2(b_s16),
    .ready(r_s16), .busy(by_s16), .done(d_s16),
    .mult_result(res_s16), .magnitude(mag_s16), .sign(sg_s16));

  int n_compared = 0;
  int n_mismatched = 0;
  bit checking = 1'b0;

  // Model: phase 0 = idle, 1..N = computing, N+1 = done cycle.
  int          phase    [3];
  longint      pend     [3];
  logic [31:0] exp_res  [3];
  logic [31:0] exp_mag  [3];
  logic        exp_sign [3];
  int          n_iter   [3] = '{9, 9, 17};
  int          width_of [3] = '{8, 8, 16};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic modelStep(input int i, input logic vin, input longint p);
    logic [63:0] mask;
    longint      mag;
    if (phase[i] == 0) begin
      if (vin) begin
        phase[i] = 1;
        pend[i]  = p;
      end
    end else if (phase[i] == n_iter[i] + 1) begin
      phase[i] = 0;
    end else begin
      phase[i]++;
      if (phase[i] == n_iter[i] + 1) begin
        mask        = (64'd1 << (2 * width_of[i])) - 64'd1;
        mag         = (pend[i] < 0) ? -pend[i] : pend[i];
        exp_res[i]  = 32'(64'(pend[i]) & mask);
        exp_mag[i]  = 32'(mag);
        exp_sign[i] = (pend[i] < 0);
      end
    end
  endtask

  always @(posedge clk) begin
    longint p0, p1, p2;
    p0 = longint'($signed(a_s8)) * longint'($signed(b_s8));
    p1 = longint'(a_u8) * longint'(b_u8);
    p2 = longint'($signed(a_s16)) * longint'($signed(b_s16));
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        phase[i] = 0; pend[i] = 0;
        exp_res[i] = '0; exp_mag[i] = '0; exp_sign[i] = 1'b0;
      end
    end else begin
      modelStep(0, v_s8, p0);
      modelStep(1, v_u8, p1);
      modelStep(2, v_s16, p2);
    end
  end

  task automatic checkInst(input int i, input string nm, input logic rdy, input logic bsy,
                           input logic dn, input logic [31:0] res, input logic [31:0] mag,
                           input logic sg);
    checkOutput({nm, ".ready"}, 64'(rdy), 64'(phase[i] == 0));
    checkOutput({nm, ".busy"},  64'(bsy), 64'(phase[i] >= 1 && phase[i] <= n_iter[i]));
    checkOutput({nm, ".done"},  64'(dn),  64'(phase[i] == n_iter[i] + 1));
    checkOutput({nm, ".mult_result"}, 64'(res), 64'(exp_res[i]));
    checkOutput({nm, ".magnitude"},   64'(mag), 64'(exp_mag[i]));
    checkOutput({nm, ".sign"},        64'(sg),  64'(exp_sign[i]));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkInst(0, "s8",  r_s8,  by_s8,  d_s8,  {16'd0, res_s8}, {16'd0, mag_s8}, sg_s8);
      checkInst(1, "u8",  r_u8,  by_u8,  d_u8,  {16'd0, res_u8}, {16'd0, mag_u8}, sg_u8);
      checkInst(2, "s16", r_s16, by_s16, d_s16, res_s16, mag_s16, sg_s16);
    end
  end

  function automatic logic selDone(input int sel);
    case (sel)
      0:       return d_s8;
      1:       return d_u8;
      default: return d_s16;
    endcase
  endfunction

  function automatic logic selReady(input int sel);
    case (sel)
      0:       return r_s8;
      1:       return r_u8;
      default: return r_s16;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge where done is seen, latency in cycles after acceptance.
  task automatic applyStimulus(input int sel, input logic [15:0] a, input logic [15:0] b,
                               output int latency);
    int guard = 0;
    while (!selReady(sel) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    case (sel)
      0:       begin v_s8 = 1'b1;  a_s8 = a[7:0];  b_s8 = b[7:0];  end
      1:       begin v_u8 = 1'b1;  a_u8 = a[7:0];  b_u8 = b[7:0];  end
      default: begin v_s16 = 1'b1; a_s16 = a;      b_s16 = b;      end
    endcase
    @(posedge clk);
    @(negedge clk);
    v_s8 = 1'b0; v_u8 = 1'b0; v_s16 = 1'b0;
    latency = 1;
    while (!selDone(sel) && latency < 40) begin
      @(negedge clk);
      latency++;
    end
    if (!selDone(sel)) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat;
    int last_done;
    int done_seen;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    checkOutput("reset.ready", 64'(r_s8), 64'd1);
    checkOutput("reset.busy",  64'(by_s8), 64'd0);
    checkOutput("reset.result", 64'(res_s8), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(0, 16'h0007, 16'h00FD, lat);
    checkOutput("s8 7x-3 latency", 64'(lat), 64'd10);
    checkOutput("s8 7x-3 result", 64'(res_s8), 64'hFFEB);
    checkOutput("s8 7x-3 magnitude", 64'(mag_s8), 64'd21);
    checkOutput("s8 7x-3 sign", 64'(sg_s8), 64'd1);

    applyStimulus(0, 16'h0080, 16'h0080, lat);
    checkOutput("s8 -128x-128 result", 64'(res_s8), 64'h4000);
    checkOutput("s8 -128x-128 magnitude", 64'(mag_s8), 64'd16384);
    checkOutput("s8 -128x-128 sign", 64'(sg_s8), 64'd0);
    applyStimulus(0, 16'h0080, 16'h007F, lat);
    checkOutput("s8 -128x127 result", 64'(res_s8), 64'hC080);
    checkOutput("s8 -128x127 magnitude", 64'(mag_s8), 64'd16256);
    checkOutput("s8 -128x127 sign", 64'(sg_s8), 64'd1);

    applyStimulus(1, 16'h00FF, 16'h00FF, lat);
    checkOutput("u8 255x255 result", 64'(res_u8), 64'hFE01);
    checkOutput("u8 255x255 magnitude", 64'(mag_u8), 64'hFE01);
    checkOutput("u8 255x255 sign", 64'(sg_u8), 64'd0);
    applyStimulus(1, 16'h0000, 16'd200, lat);
    checkOutput("u8 0x200 latency", 64'(lat), 64'd10);
    checkOutput("u8 0x200 result", 64'(res_u8), 64'd0);
    checkOutput("u8 0x200 magnitude", 64'(mag_u8), 64'd0);

    // Abort a running operation with reset four cycles after acceptance.
    @(negedge clk);
    v_s8 = 1'b1; a_s8 = 8'd5; b_s8 = 8'd6;
    @(posedge clk);
    @(negedge clk);
    v_s8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort ready", 64'(r_s8), 64'd1);
    checkOutput("abort done", 64'(d_s8), 64'd0);
    checkOutput("abort result", 64'(res_s8), 64'd0);
    checkOutput("abort sign", 64'(sg_s8), 64'd0);
    applyStimulus(0, 16'd5, 16'd6, lat);
    checkOutput("s8 5x6 result", 64'(res_s8), 64'd30);

    // valid held high while operands change every cycle.
    @(negedge clk);
    last_done = -1;
    done_seen = 0;
    v_s8 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a_s8 = 8'(i * 3 + 1);
      b_s8 = 8'(100 - i * 7);
      @(negedge clk);
      if (d_s8) begin
        if (last_done >= 0) checkOutput("done spacing", 64'(i - last_done), 64'd11);
        last_done = i;
        done_seen++;
      end
    end
    v_s8 = 1'b0;
    checkOutput("held-valid done count", 64'(done_seen >= 4), 64'd1);

    applyStimulus(2, 16'h8000, 16'h8000, lat);
    checkOutput("s16 min^2 latency", 64'(lat), 64'd18);
    checkOutput("s16 min^2 result", 64'(res_s16), 64'h40000000);
    checkOutput("s16 min^2 sign", 64'(sg_s16), 64'd0);
    applyStimulus(2, 16'h8000, 16'h7FFF, lat);
    checkOutput("s16 min*max result", 64'(res_s16), 64'hC0008000);
    checkOutput("s16 min*max magnitude", 64'(mag_s16), 64'h3FFF8000);
    applyStimulus(2, 16'h7FFF, 16'h8000, lat);
    applyStimulus(2, 16'h0000, 16'h8000, lat);
    for (int i = 0; i < 996; i++) begin
      applyStimulus(2, 16'($urandom), 16'($urandom), lat);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
Parametrised sequential radix-2 Booth multiplier. It merges the multiplier control FSM, the datapath and the sign/magnitude split into one block with a valid/ready/done handshake. It sits between the keypad operand controller (source of num_1, num_2, valid) and the binary-to-BCD converter (consumer of magnitude, sign, done). It generalises the fixed 8-bit signed multiplier to any operand width and adds an unsigned mode.

Parameters:
WIDTH, 8, operand width in bits (range 2..32).
SIGNED, 1, 1 = two's-complement operands; 0 = unsigned operands.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
valid  input  1  operands on num_1/num_2 are valid; sampled only when ready=1.
num_1  input  WIDTH  multiplicand M.
num_2  input  WIDTH  multiplier Q.
ready  output  1  block idle and able to accept operands.
busy  output  1  multiplication in progress.
done  output  1  one-cycle pulse; result outputs are updated in the same cycle.
mult_result  output  2*WIDTH  product (two's complement if SIGNED=1, unsigned otherwise).
magnitude  output  2*WIDTH  absolute value of the product.
sign  output  1  1 when the product is negative (always 0 when SIGNED=0).

Behaviour:
- Reset (synchronous, sampled at clk edge) has priority over everything and may occur in any state. Values after reset: state=IDLE, ready=1, busy=0, done=0, mult_result=0, magnitude=0, sign=0, internal A/Q/Qprev/count=0.
- Internal datapath: accumulator A and M register are WIDTH+1 bits, Q is WIDTH+1 bits, Qprev is 1 bit, count is ceil(log2(WIDTH+2)) bits.
- The extra bit in A and M is mandatory so that A-M with M=-2^(WIDTH-1) does not overflow.
- Operand extension: SIGNED=1 sign-extends num_1/num_2 to WIDTH+1 bits. SIGNED=0 zero-extends them.
- Iteration count: N = WIDTH+1 in both modes.
- FSM states: IDLE, CALC, DONE.
- IDLE: ready=1, busy=0.
  - On a clk edge with valid=1: load M and Q with the extended operands, A=0, Qprev=0, count=N, go to CALC.
  - valid=0: stay in IDLE.
- CALC: ready=0, busy=1. Each cycle performs one iteration:
  - {Q[0],Qprev}=01: A=A+M.
  - {Q[0],Qprev}=10: A=A-M.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,Qprev} by one, with A's MSB replicated.
  - count decrements. The edge performing the iteration that takes count from 1 to 0 moves the FSM to DONE.
- DONE (exactly one cycle): ready=0, busy=0, done=1. Return to IDLE on the next edge.
  - On the edge entering DONE, register mult_result = low 2*WIDTH bits of {A,Q} after the final shift.
  - sign = SIGNED & mult_result[2*WIDTH-1].
  - magnitude = sign ? -mult_result : mult_result.
- Latency: operands accepted at edge E0; done=1 in the cycle after edge E0+N; ready returns to 1 one cycle later. Throughput is one product per N+2 cycles.
- mult_result, magnitude and sign hold their values until the next done pulse. They do not change during CALC.
- valid, num_1 and num_2 are ignored outside IDLE. Operands are captured at acceptance, so they may change afterwards.
- valid held high continuously: a new operation is accepted at the first IDLE edge. No operation is lost or duplicated.
- Range: a WIDTH-bit x WIDTH-bit product always fits in 2*WIDTH bits, so there is no overflow flag.
  - Worst signed case: (-2^(W-1))^2 = 2^(2W-2), which is positive.
  - Magnitude never exceeds 2^(2W-2) in signed mode.
- Reset in CALC or DONE aborts the operation. done is not pulsed, outputs return to reset values, and ready=1 in the cycle after the reset edge.

Test Plan:
- WIDTH=8, SIGNED=1, num_1=7, num_2=-3 (0xFD), valid for 1 cycle -> done exactly 10 cycles after acceptance edge (N=9); mult_result=0xFFEB, magnitude=21, sign=1.
- WIDTH=8, SIGNED=1, -128 x -128 -> mult_result=0x4000, magnitude=16384, sign=0. Then -128 x 127 -> 0xC080, magnitude=16256, sign=1. Confirms the extra A bit.
- WIDTH=8, SIGNED=0, 255 x 255 -> mult_result=0xFE01, magnitude=0xFE01, sign=0. Then 0 x 200 -> all-zero outputs, done still pulses.
- WIDTH=8: accept 5 x 6, assert reset 4 cycles later -> no done pulse, outputs=0, ready=1 the cycle after reset. Then 5 x 6 -> 30.
- valid held high with operand pairs changing every cycle -> each accepted pair is only the one present at an IDLE edge. Products match, done pulses spaced N+2 cycles, ready=0 throughout CALC/DONE.
- WIDTH=16, SIGNED=1, random 1000 pairs including ±2^15 extremes vs reference model -> all mult_result/magnitude/sign match. Outputs are stable between done pulses.
